// File: rtl/mp_test_pipe_pkg.sv
// Shared types and helpers for the macro-placement test pipeline.
// Pure declarations: no state, no latency.
// No flow control here; the permutation helper is combinational.
package mp_test_pipe_pkg;

    // Channel permutation applied by the hub slice
    typedef enum logic [1:0] {
        HUB_PASS  = 2'd0,
        HUB_ROTL  = 2'd1,
        HUB_REV   = 2'd2,
        HUB_BCAST = 2'd3
    } hub_mode_e;

    // Source channel feeding output channel c for a given mode and channel count.
    // Returning an index keeps the helper width-agnostic (works for any NUM_CH/DATA_W).
    function automatic int unsigned perm(input hub_mode_e mode,
                                         input int unsigned c,
                                         input int unsigned num_ch);
        int unsigned src;
        src = 0;
        case (mode)
            HUB_PASS:  src = c;
            HUB_ROTL:  src = (c + 1) % num_ch;
            HUB_REV:   src = num_ch - 1 - c;
            default:   src = 0;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/mp_pipe_slice.sv
// Generic pipeline slice: 1-entry register, or 2-entry skid buffer when SKID=1.
// Latency: 1 cycle from upstream handshake to dn_vld in both variants.
// Backpressure: register form passes dn_rdy combinationally; skid form drives up_rdy from a flop.
module mp_pipe_slice #(
    parameter int W    = 32,
    parameter bit SKID = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [W-1:0] up_dat,
    output logic         dn_vld,
    input  logic         dn_rdy,
    output logic [W-1:0] dn_dat
);

    if (SKID) begin : g_skid
        logic         main_full_q;
        logic         skid_full_q;
        logic [W-1:0] main_q;
        logic [W-1:0] skid_q;
        logic         push;
        logic         pop;

        // up_rdy comes straight from a flop, so no ready path crosses this slice
        assign up_rdy = !skid_full_q;
        assign push   = up_vld && !skid_full_q;
        assign pop    = main_full_q && dn_rdy;
        assign dn_vld = main_full_q;
        assign dn_dat = main_q;

        // Main register refills from skid first (ordering), else directly from upstream
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                main_full_q <= 1'b0;
                skid_full_q <= 1'b0;
                main_q      <= '0;
                skid_q      <= '0;
            end else if (pop || !main_full_q) begin
                if (skid_full_q) begin
                    main_q      <= skid_q;
                    main_full_q <= 1'b1;
                    skid_full_q <= 1'b0;
                end else begin
                    main_full_q <= push;
                    if (push) begin
                        main_q <= up_dat;
                    end
                end
            end else if (push) begin
                skid_q      <= up_dat;
                skid_full_q <= 1'b1;
            end
        end
    end else begin : g_reg
        logic         full_q;
        logic [W-1:0] dat_q;

        // Accept when empty or when the current beat leaves this same cycle
        assign up_rdy = !full_q || dn_rdy;
        assign dn_vld = full_q;
        assign dn_dat = dat_q;

        // Single-entry load; data held untouched while stalled
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                full_q <= 1'b0;
                dat_q  <= '0;
            end else if (up_rdy) begin
                full_q <= up_vld;
                if (up_vld) begin
                    dat_q <= up_dat;
                end
            end
        end
    end

endmodule

// File: rtl/mp_test_pipe.sv
// Placement benchmark pipe: STAGES slices, a permuting hub slice, STAGES slices; MP_TEST_PIPE_SKID_EN selects skid slices.
// Latency: 2*STAGES+1 cycles from input handshake to out_valid with out_ready high.
// Backpressure: valid/ready end to end; holds 2*STAGES+1 beats (twice that with skid slices) when stalled.
module mp_test_pipe
    import mp_test_pipe_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [1:0]               hub_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam int W   = NUM_CH * DATA_W;
    localparam int NSL = 2 * STAGES + 1;

`ifdef MP_TEST_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    // Link s sits in front of slice s; link NSL is the pipe output
    logic         link_vld [NSL+1];
    logic         link_rdy [NSL+1];
    logic [W-1:0] link_dat [NSL+1];
    logic [W-1:0] hub_din;
    hub_mode_e    mode;

    assign mode           = hub_mode_e'(hub_mode);
    assign link_vld[0]    = in_valid;
    assign link_dat[0]    = in_data;
    assign in_ready       = link_rdy[0];
    assign link_rdy[NSL]  = out_ready;
    assign out_valid      = link_vld[NSL];
    assign out_data       = link_dat[NSL];

    // Permute the beat as it enters the hub; mode is captured with the beat at load time
    always_comb begin
        hub_din = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hub_din[c*DATA_W +: DATA_W] = link_dat[STAGES][perm(mode, c, NUM_CH)*DATA_W +: DATA_W];
        end
    end

    for (genvar s = 0; s < NSL; s++) begin : g_slice
        logic [W-1:0] din;

        if (s == STAGES) begin : g_hub
            assign din = hub_din;
        end else begin : g_plain
            assign din = link_dat[s];
        end

        mp_pipe_slice #(
            .W    (W),
            .SKID (SKID)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .up_vld (link_vld[s]),
            .up_rdy (link_rdy[s]),
            .up_dat (din),
            .dn_vld (link_vld[s+1]),
            .dn_rdy (link_rdy[s+1]),
            .dn_dat (link_dat[s+1])
        );
    end

    // Count output handshakes; wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mp_test_pipe.sv
// Scoreboard bench for mp_test_pipe: driver pushes expected beats, negedge monitor pops and compares.
// Inputs change 1 time unit after posedge; all sampling happens on negedge.
module tb_mp_test_pipe;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;
    localparam int W      = NUM_CH * DATA_W;
    localparam int DEPTH  = 2 * STAGES + 1;
`ifdef MP_TEST_PIPE_SKID_EN
    localparam int CAP = 2 * DEPTH;
`else
    localparam int CAP = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [1:0]       hub_mode = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] beat_cnt;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cnt = 0;
    int           ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_dat = '0;

    always #5 clk = ~clk;

    mp_test_pipe #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hub_mode  (hub_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt)
    );

    // Reference permutation written from the channel rules
    function automatic logic [W-1:0] model_perm(input logic [W-1:0] d, input logic [1:0] m);
        logic [DATA_W-1:0] ch [NUM_CH];
        logic [W-1:0]      r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) ch[c] = d[c*DATA_W +: DATA_W];
        for (int c = 0; c < NUM_CH; c++) begin
            case (m)
                2'd0:    r[c*DATA_W +: DATA_W] = ch[c];
                2'd1:    r[c*DATA_W +: DATA_W] = ch[(c + 1) % NUM_CH];
                2'd2:    r[c*DATA_W +: DATA_W] = ch[NUM_CH - 1 - c];
                default: r[c*DATA_W +: DATA_W] = ch[0];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat until accepted; m is the hub mode that will be in force when it reaches the hub
    task automatic send(input logic [W-1:0] d, input logic [1:0] m);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model_perm(d, m));
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        check("send_accept", {63'd0, done}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: beat order/data, stall stability, beat counter
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                check("beat_cnt", beat_cnt, exp_cnt);
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_dat);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stale_beat actual=0x%0h required=none at %0t", out_data, $time);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                    end
                    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                end
                prev_stall = out_valid && !out_ready;
                prev_dat   = out_data;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int acc;
        logic stale;
        logic [1:0] modes [3];
        logic [1:0] m;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        tick();

        // 1: single PASS beat, latency counted from the handshake cycle
        hub_mode = 2'd0;
        in_valid = 1'b1;
        in_data  = 32'h13121110;
        @(negedge clk);
        check("t1_in_ready", in_ready, 1);
        if (in_ready) exp_q.push_back(32'h13121110);
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("t1_latency", lat, DEPTH);
        check("t1_data", out_data, 32'h13121110);
        tick();
        drain();
        @(negedge clk);
        check("t1_beat_cnt", beat_cnt, 1);
        tick();

        // 2: back-to-back ROTL, REV, BCAST; mode is presented as each beat reaches the hub
        modes[0] = 2'd1;
        modes[1] = 2'd2;
        modes[2] = 2'd3;
        for (int i = 0; i <= 2 + STAGES; i++) begin
            in_valid = (i < 3);
            in_data  = 32'h03020100;
            hub_mode = (i >= STAGES && i - STAGES < 3) ? modes[i - STAGES] : 2'd0;
            @(negedge clk);
            if (i < 3) begin
                check("t2_in_ready", in_ready, 1);
                if (in_ready) begin
                    case (i)
                        0:       exp_q.push_back(32'h00030201);
                        1:       exp_q.push_back(32'h00010203);
                        default: exp_q.push_back(32'h00000000);
                    endcase
                end
            end
            tick();
        end
        in_valid = 1'b0;
        hub_mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_tput", out_valid, 1);
            tick();
        end
        drain();

        // 3: stalled output, continuous input fills the pipe to capacity
        ready_mode = 1;
        tick();
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 3 * CAP; i++) begin
            in_data = $urandom;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(in_data);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("t3_accepted", acc, CAP);
        @(negedge clk);
        check("t3_in_ready_low", in_ready, 0);
        tick();
        ready_mode = 0;
        drain();

        // 4: random valid/ready over 1000 beats, hub mode changed only between drained segments
        for (int seg = 0; seg < 4; seg++) begin
            m = 2'($urandom_range(0, 3));
            hub_mode = m;
            ready_mode = 2;
            for (int b = 0; b < 250; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                send($urandom, m);
            end
            drain();
            ready_mode = 0;
            tick();
        end
        hub_mode = 2'd0;

        // 5: reset pulse with three beats in flight
        ready_mode = 1;
        tick();
        for (int b = 0; b < 3; b++) send($urandom, 2'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check("t5_beat_cnt", beat_cnt, 0);
        check("t5_in_ready", in_ready, 1);
        tick();
        ready_mode = 0;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            stale = stale | out_valid;
            tick();
        end
        check("t5_no_stale", stale, 0);

        // 6: counter wrap with CNT_W=4
        for (int b = 0; b < 15; b++) send(32'(b), 2'd0);
        drain();
        @(negedge clk);
        check("t6_cnt_15", beat_cnt, 15);
        tick();
        send(32'hAA, 2'd0);
        drain();
        @(negedge clk);
        check("t6_cnt_0", beat_cnt, 0);
        tick();
        send(32'hBB, 2'd0);
        drain();
        @(negedge clk);
        check("t6_cnt_1", beat_cnt, 1);
        tick();

        repeat (5) tick();
        check("final_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
